// File: rtl/nv_pg_seq.sv
// Power-gate sequencer: staggers the partition sleep-enable chain on/off one
// segment at a time and controls the isolation clamp and the level acknowledge.
module nv_pg_seq #(
    parameter int unsigned NUM_SEG   = 4,
    parameter int unsigned STAGGER_W = 8
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 pwr_on_req,
    input  logic [STAGGER_W-1:0] pwr_stagger,
    output logic [NUM_SEG-1:0]   pwr_seg_en,
    output logic                 pwr_iso_en,
    output logic                 pwr_on_ack,
    output logic                 pwr_busy
);

    localparam int unsigned        IDX_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SEG - 1);
    localparam logic [NUM_SEG-1:0] SEG_ONE  = NUM_SEG'(1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_PWRUP,
        ST_ON,
        ST_PWRDN
    } state_t;

    state_t               state;
    logic [STAGGER_W-1:0] cnt;
    logic [STAGGER_W-1:0] s_lat;
    logic [IDX_W-1:0]     idx;

    // Sequencer; stagger is latched when a sequence starts so mid-sequence
    // changes of pwr_stagger or pwr_on_req cannot disturb it.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state      <= ST_OFF;
            cnt        <= '0;
            s_lat      <= '0;
            idx        <= '0;
            pwr_seg_en <= '0;
            pwr_iso_en <= 1'b1;
            pwr_on_ack <= 1'b0;
            pwr_busy   <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (pwr_on_req) begin
                        state      <= ST_PWRUP;
                        s_lat      <= pwr_stagger;
                        cnt        <= pwr_stagger;
                        idx        <= '0;
                        pwr_seg_en <= pwr_seg_en | SEG_ONE;
                        pwr_busy   <= 1'b1;
                    end
                end
                ST_PWRUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - STAGGER_W'(1);
                    end else if (idx < LAST_IDX) begin
                        idx        <= idx + IDX_W'(1);
                        pwr_seg_en <= pwr_seg_en | (SEG_ONE << (idx + IDX_W'(1)));
                        cnt        <= s_lat;
                    end else begin
                        // Last segment has settled for s_lat+1 cycles: unclamp.
                        state      <= ST_ON;
                        pwr_iso_en <= 1'b0;
                        pwr_on_ack <= 1'b1;
                        pwr_busy   <= 1'b0;
                    end
                end
                ST_ON: begin
                    if (!pwr_on_req) begin
                        state      <= ST_PWRDN;
                        pwr_iso_en <= 1'b1;
                        pwr_on_ack <= 1'b0;
                        pwr_busy   <= 1'b1;
                        s_lat      <= pwr_stagger;
                        cnt        <= pwr_stagger;
                        idx        <= LAST_IDX;
                    end
                end
                ST_PWRDN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - STAGGER_W'(1);
                    end else begin
                        pwr_seg_en <= pwr_seg_en & ~(SEG_ONE << idx);
                        if (idx == '0) begin
                            state    <= ST_OFF;
                            pwr_busy <= 1'b0;
                        end else begin
                            idx <= idx - IDX_W'(1);
                            cnt <= s_lat;
                        end
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule
